// File: rtl/crg_switch_sequencer.sv
// crg_switch_sequencer
//   Per-channel reconfiguration sequencer for the clock-reset generator.
//   One request at a time is accepted on a valid/ready interface. A PLL
//   change gates the channel, holds it in reset across the mux switch, waits
//   for the switch to settle, then releases reset and restores the enable.
//   A request that keeps the current PLL only updates the enable.
//
// Ports
//   ref_clk_i     sole clock (rising edge)
//   glob_arst_ni  synchronous active-low reset
//   req_valid_i / req_ready_o   request handshake
//   req_ch_i, req_sel_i, req_en_i   target channel, PLL index, final enable
//   sel_o, en_o, arst_req_o     per-channel controls to the CRG
//   done_o, err_o, done_ch_o    completion / rejection pulses and channel
//   busy_o        sequencer not idle

// Output registers for one channel; written only through strobes.
module crg_switch_lane #(
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel_we,
  input  logic [SW-1:0] sel_d,
  input  logic          en_we,
  input  logic          en_d,
  input  logic          arst_we,
  input  logic          arst_d,
  output logic [SW-1:0] sel,
  output logic          en,
  output logic          arst
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel  <= '0;
      en   <= 1'b1;
      arst <= 1'b0;
    end else begin
      if (sel_we)  sel  <= sel_d;
      if (en_we)   en   <= en_d;
      if (arst_we) arst <= arst_d;
    end
  end
endmodule

module crg_switch_sequencer #(
  parameter int M             = 4,
  parameter int N             = 8,
  parameter int GATE_CYCLES   = 4,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 128,
  localparam int SW  = $clog2(M),
  localparam int CHW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  ref_clk_i,
  input  logic                  glob_arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CHW-1:0]        req_ch_i,
  input  logic [SW-1:0]         req_sel_i,
  input  logic                  req_en_i,
  output logic [N-1:0][SW-1:0]  sel_o,
  output logic [N-1:0]          en_o,
  output logic [N-1:0]          arst_req_o,
  output logic                  done_o,
  output logic [CHW-1:0]        done_ch_o,
  output logic                  err_o,
  output logic                  busy_o
);
  localparam int MAX_GR = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
  localparam int MAXC   = (MAX_GR > SETTLE_CYCLES) ? MAX_GR : SETTLE_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);
  localparam logic [CW-1:0] G_LD = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] R_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GATE, RST, SETTLE, RELEASE, DONE, ERR} state_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [SW-1:0]  sel;
    logic           en;
  } req_t;

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          cur;

  logic           hs, ch_ok, same_sel, last;
  logic [SW-1:0]  req_cur_sel;
  logic [CHW-1:0] tgt_ch;
  logic           sel_we, en_we, en_d, arst_we, arst_d;

  assign hs    = req_valid_i && req_ready_o && (state == IDLE);
  assign ch_ok = {1'b0, req_ch_i} < (CHW+1)'(N);
  assign last  = (cnt == '0);

  // Current PLL of the requested channel; zero for an out-of-range channel.
  always_comb begin
    req_cur_sel = '0;
    for (int i = 0; i < N; i++)
      if (req_ch_i == CHW'(i)) req_cur_sel = sel_o[i];
  end
  assign same_sel = (req_cur_sel == req_sel_i);

  // Output write strobes, aligned with the FSM transition edges.
  always_comb begin
    tgt_ch  = cur.ch;
    sel_we  = 1'b0;
    en_we   = 1'b0;
    en_d    = 1'b0;
    arst_we = 1'b0;
    arst_d  = 1'b0;
    case (state)
      IDLE: begin
        tgt_ch = req_ch_i;
        if (hs && ch_ok) begin
          en_we = 1'b1;
          en_d  = same_sel ? req_en_i : 1'b0;
        end
      end
      GATE:    if (last) begin arst_we = 1'b1; arst_d = 1'b1; end
      RST:     if (last) sel_we = 1'b1;
      SETTLE:  if (last) begin arst_we = 1'b1; arst_d = 1'b0; end
      RELEASE: if (last) begin en_we = 1'b1; en_d = cur.en; end
      default: ;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic hit;
    assign hit = (tgt_ch == CHW'(i));
    crg_switch_lane #(.SW(SW)) u_lane (
      .clk     (ref_clk_i),
      .rst_n   (glob_arst_ni),
      .sel_we  (sel_we && hit),
      .sel_d   (cur.sel),
      .en_we   (en_we && hit),
      .en_d    (en_d),
      .arst_we (arst_we && hit),
      .arst_d  (arst_d),
      .sel     (sel_o[i]),
      .en      (en_o[i]),
      .arst    (arst_req_o[i])
    );
  end

  always_ff @(posedge ref_clk_i) begin
    if (!glob_arst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      cur         <= '0;
      req_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      done_ch_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          if (hs) begin
            cur         <= '{ch: req_ch_i, sel: req_sel_i, en: req_en_i};
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (!ch_ok) begin
              state     <= ERR;
              err_o     <= 1'b1;
              done_ch_o <= req_ch_i;
            end else if (same_sel) begin
              state     <= DONE;
              done_o    <= 1'b1;
              done_ch_o <= req_ch_i;
            end else begin
              state <= GATE;
              cnt   <= G_LD;
            end
          end
        end
        GATE:
          if (last) begin state <= RST; cnt <= R_LD; end
          else cnt <= cnt - CW'(1);
        RST:
          if (last) begin state <= SETTLE; cnt <= S_LD; end
          else cnt <= cnt - CW'(1);
        SETTLE:
          if (last) begin state <= RELEASE; cnt <= S_LD; end
          else cnt <= cnt - CW'(1);
        RELEASE:
          if (last) begin
            state     <= DONE;
            done_o    <= 1'b1;
            done_ch_o <= cur.ch;
          end else cnt <= cnt - CW'(1);
        DONE, ERR: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crg_switch_sequencer.sv
// Testbench for crg_switch_sequencer (N = 6 so out-of-range channels exist).
module tb_crg_switch_sequencer;
  localparam int M = 4, N = 6, G = 4, R = 8, S = 128;
  localparam int SW = 2, CHW = 3;
  localparam int T = G + R + 2 * S;
  localparam int TMAX = T + 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [CHW-1:0] req_ch = '0;
  logic [SW-1:0]  req_sel = '0;
  logic           req_en = 1'b0;
  logic req_ready, done, err, busy;
  logic [CHW-1:0] done_ch;
  logic [N-1:0][SW-1:0] sel_o;
  logic [N-1:0] en_o, arst_o;

  crg_switch_sequencer #(.M(M), .N(N), .GATE_CYCLES(G), .RST_CYCLES(R),
                         .SETTLE_CYCLES(S)) dut (
    .ref_clk_i(clk), .glob_arst_ni(rst_n), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_ch_i(req_ch), .req_sel_i(req_sel),
    .req_en_i(req_en), .sel_o(sel_o), .en_o(en_o), .arst_req_o(arst_o),
    .done_o(done), .done_ch_o(done_ch), .err_o(err), .busy_o(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][SW-1:0] sel;
    logic [N-1:0] en;
    logic [N-1:0] arst;
    logic done, err, busy, ready;
    logic [CHW-1:0] dch;
  } obs_t;

  obs_t trace [0:TMAX];
  obs_t exp_tr[0:TMAX];
  int checks = 0, errors = 0, waited;

  // Reference state: settled per-channel outputs between requests.
  logic [N-1:0][SW-1:0] m_sel = '0;
  logic [N-1:0]         m_en  = '1;

  function automatic obs_t snap();
    obs_t o;
    o.sel = sel_o; o.en = en_o; o.arst = arst_o;
    o.done = done; o.err = err; o.busy = busy; o.ready = req_ready;
    o.dch = (done || err) ? done_ch : '0;
    return o;
  endfunction

  function automatic obs_t reset_vec();
    obs_t o;
    o = '0;
    o.en = '1;
    return o;
  endfunction

  function automatic int dur_of(input int ch, input int sel);
    if (ch >= N || m_sel[ch] == SW'(sel)) return 0;
    return T;
  endfunction

  // Expected outputs t cycles after the accepting edge, from the timeline rules.
  function automatic void build_exp(input int ch, input int sel, input logic en, input int n);
    int dur;
    dur = dur_of(ch, sel);
    for (int t = 0; t < n; t++) begin
      obs_t e;
      e = '0;
      e.sel = m_sel; e.en = m_en; e.arst = '0;
      if (ch >= N) begin
        e.err = (t == 0);
        if (t == 0) e.dch = CHW'(ch);
      end else if (dur == 0) begin
        e.en[ch] = en;
        e.done = (t == 0);
        if (t == 0) e.dch = CHW'(ch);
      end else begin
        e.en[ch]   = (t < T) ? 1'b0 : en;
        e.arst[ch] = (t >= G) && (t < G + R + S);
        e.sel[ch]  = (t >= G + R) ? SW'(sel) : m_sel[ch];
        e.done     = (t == T);
        if (t == T) e.dch = CHW'(ch);
      end
      e.busy  = (t <= dur);
      e.ready = (t > dur);
      exp_tr[t] = e;
    end
  endfunction

  function automatic void commit(input int ch, input int sel, input logic en);
    if (ch < N) begin
      m_sel[ch] = SW'(sel);
      m_en[ch]  = en;
    end
  endfunction

  // Called at a sample point; returns just after the accepting edge.
  task automatic issue(input int ch, input int sel, input logic en);
    waited = 0;
    while (!req_ready && waited < 1000) begin
      @(posedge clk); #1; waited++;
    end
    req_valid = 1'b1; req_ch = CHW'(ch); req_sel = SW'(sel); req_en = en;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic record(input int n);
    for (int t = 0; t < n; t++) begin
      trace[t] = snap();
      if (t < n - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    o = snap();
    checks++;
    if (o !== reset_vec()) begin
      errors++; $display("FAIL reset_state got %h exp %h", o, reset_vec());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_full_switch();
    issue(3, 2, 1'b1);
    build_exp(3, 2, 1'b1, T + 3);
    record(T + 3);
    for (int t = 0; t < T + 3; t++) begin
      checks++;
      if (trace[t] !== exp_tr[t]) begin
        errors++; $display("FAIL full_switch t=%0d got %h exp %h", t, trace[t], exp_tr[t]);
      end
    end
    commit(3, 2, 1'b1);
  endtask

  task automatic test_same_sel();
    issue(5, 0, 1'b0);
    build_exp(5, 0, 1'b0, 3);
    record(3);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (trace[t] !== exp_tr[t]) begin
        errors++; $display("FAIL same_sel t=%0d got %h exp %h", t, trace[t], exp_tr[t]);
      end
    end
    commit(5, 0, 1'b0);
  endtask

  task automatic test_invalid_ch();
    issue(7, 1, 1'b0);
    build_exp(7, 1, 1'b0, 3);
    record(3);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (trace[t] !== exp_tr[t]) begin
        errors++; $display("FAIL invalid_ch t=%0d got %h exp %h", t, trace[t], exp_tr[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(2, 1, 1'b1);
    // Second request held valid for the whole first sequence.
    req_valid = 1'b1; req_ch = 3'd4; req_sel = 2'd3; req_en = 1'b1;
    build_exp(2, 1, 1'b1, T + 2);
    record(T + 2);
    for (int t = 0; t < T + 2; t++) begin
      checks++;
      if (trace[t] !== exp_tr[t]) begin
        errors++; $display("FAIL backpressure t=%0d got %h exp %h", t, trace[t], exp_tr[t]);
      end
    end
    commit(2, 1, 1'b1);
    issue(4, 3, 1'b1);
    checks++;
    if (waited !== 0) begin
      errors++; $display("FAIL b2b_accept_delay got %0d exp 0", waited);
    end
    build_exp(4, 3, 1'b1, T + 2);
    record(T + 2);
    for (int t = 0; t < T + 2; t++) begin
      checks++;
      if (trace[t] !== exp_tr[t]) begin
        errors++; $display("FAIL b2b_second t=%0d got %h exp %h", t, trace[t], exp_tr[t]);
      end
    end
    commit(4, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int pulses;
    issue(1, 3, 1'b1);
    build_exp(1, 3, 1'b1, G + R + 6);
    record(G + R + 6);
    for (int t = 0; t < G + R + 6; t++) begin
      checks++;
      if (trace[t] !== exp_tr[t]) begin
        errors++; $display("FAIL mid_prefix t=%0d got %h exp %h", t, trace[t], exp_tr[t]);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    o = snap();
    checks++;
    if (o !== reset_vec()) begin
      errors++; $display("FAIL mid_reset got %h exp %h", o, reset_vec());
    end
    m_sel = '0; m_en = '1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (2 * T) begin
      @(posedge clk); #1;
      if (done || err || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL mid_no_done got %0d activity cycles exp 0", pulses);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      int ch, sel, n;
      logic en;
      ch  = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      en  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      n = dur_of(ch, sel) + 3;
      issue(ch, sel, en);
      build_exp(ch, sel, en, n);
      record(n);
      for (int t = 0; t < n; t++) begin
        checks++;
        if (trace[t] !== exp_tr[t]) begin
          errors++;
          $display("FAIL random%0d ch=%0d sel=%0d t=%0d got %h exp %h", k, ch, sel, t, trace[t], exp_tr[t]);
        end
      end
      commit(ch, sel, en);
    end
  endtask

  initial begin
    test_reset();
    test_full_switch();
    test_same_sel();
    test_invalid_ch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crg_switch_sequencer.md
Name: crg_switch_sequencer

Overview:
- Per-channel configuration sequencer that drives the sel_i / en_i / arst_req_i inputs of the clock-reset generator top (N output clocks, each muxed from M PLLs).
- Accepts one reconfiguration request at a time on a valid/ready interface.
- For a PLL change it gates the channel, holds it in reset across the mux switch, waits for the switch to settle, then releases reset and restores enable.
- Runs on the CRG reference clock.

Parameters:
- M, 4, number of PLL sources per channel (≥2)
- N, 8, number of output clock channels (≥1)
- GATE_CYCLES, 4, cycles en_o is held low before reset asserts (≥1)
- RST_CYCLES, 8, cycles reset is held before sel_o changes (≥1)
- SETTLE_CYCLES, 128, cycles waited after sel change and again after reset release (≥1; 128 × 10 ns covers the 1280 ns switch latency)

Ports:
- ref_clk_i  in  1  sole clock, all logic on rising edge
- glob_arst_ni  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_ch_i  in  $clog2(N)  target channel
- req_sel_i  in  $clog2(M)  requested PLL index
- req_en_i  in  1  requested final enable
- sel_o  out  [N] x $clog2(M)  per-channel PLL select to CRG
- en_o  out  [N] x 1  per-channel clock enable to CRG
- arst_req_o  out  [N] x 1  per-channel reset request to CRG
- done_o  out  1  one-cycle completion pulse
- done_ch_o  out  $clog2(N)  channel of completed/rejected request, valid with done_o/err_o
- err_o  out  1  one-cycle pulse, request rejected
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: synchronous; glob_arst_ni low at an edge has the following effects:
  - all sel_o = 0, all en_o = 1, all arst_req_o = 0
  - done_o = 0, err_o = 0, done_ch_o = 0, busy_o = 0, req_ready_o = 0
  - FSM goes to IDLE, counter goes to 0
  - A sequence in progress is aborted; no done_o pulse is produced for it.
- req_ready_o = 1 only in IDLE with glob_arst_ni high. Handshake occurs at an edge where valid && ready. ch/sel/en are latched at that edge. Inputs are ignored otherwise.
- busy_o = (state != IDLE). Only one channel is sequenced at a time. Other channels' outputs never change during a sequence.
- FSM states: IDLE, GATE, RST, SETTLE, RELEASE, DONE, ERR.
- Accept at edge k, req_ch_i ≥ N: next state ERR. err_o = 1 and done_ch_o = req_ch_i during the following cycle, then IDLE. No outputs change.
- Accept, req_sel_i == sel_o[ch] (no switch): en_o[ch] <= req_en_i at edge k. State DONE, then IDLE. arst_req_o and sel_o are untouched.
- Accept, sel differs: at edge k, en_o[ch] <= 0 and state GATE with cnt = GATE_CYCLES-1. Each wait state decrements cnt every cycle and exits at the edge where cnt == 0.
  - GATE exit: arst_req_o[ch] <= 1, RST, cnt = RST_CYCLES-1.
  - RST exit: sel_o[ch] <= latched sel, SETTLE, cnt = SETTLE_CYCLES-1.
  - SETTLE exit: arst_req_o[ch] <= 0, RELEASE, cnt = SETTLE_CYCLES-1.
  - RELEASE exit: en_o[ch] <= latched en, DONE.
- Switch-case timing relative to edge k:
  - arst_req_o rises at k+GATE_CYCLES
  - sel_o changes at k+GATE_CYCLES+RST_CYCLES
  - arst_req_o falls at k+GATE+RST+SETTLE
  - en_o restored at k+GATE+RST+2·SETTLE
- DONE: done_o = 1 and done_ch_o = ch for exactly one cycle. Next state IDLE; req_ready_o is high the cycle after DONE.
- Invariants:
  - sel_o[ch] never changes while en_o[ch] = 1 or arst_req_o[ch] = 0.
  - en_o[ch] is never 1 while arst_req_o[ch] = 1.
- Counter width: $clog2(max(GATE,RST,SETTLE)+1). No wrap; it is reloaded on every state entry.
- req_valid_i asserted while busy: it is held off (ready low) and not dropped. Back-to-back requests are accepted no sooner than 1 cycle after DONE.

Test Plan:
- Reset release:
  - Stimulus: hold glob_arst_ni low 5 cycles, then release.
  - Required: sel_o all 0, en_o all 1, arst_req_o all 0, req_ready_o rises on the first cycle after release.
- Full switch, defaults:
  - Stimulus: ch = 3, sel 0→2, en = 1, accepted at edge k.
  - Required: en_o[3] falls at k; arst_req_o[3] rises at k+4; sel_o[3] = 2 at k+12; arst_req_o[3] falls at k+140; en_o[3] = 1 at k+268; done_o = 1 with done_ch_o = 3 for one cycle; other channels constant throughout.
- Same-sel enable change:
  - Stimulus: ch = 5, sel = current 0, en = 0.
  - Required: en_o[5] = 0 at edge k; arst_req_o[5] stays 0; done_o pulses the next cycle; req_ready_o is high 2 cycles after k.
- Invalid channel:
  - Stimulus: N = 6, request ch = 7.
  - Required: err_o = 1 with done_ch_o = 7 for one cycle, no output change, no done_o.
- Backpressure:
  - Stimulus: hold a second request valid during the first sequence.
  - Required: req_ready_o low for the whole sequence; second request accepted the cycle after done_o, its fields unaltered.
- Reset mid-sequence:
  - Stimulus: assert glob_arst_ni low during SETTLE of a ch = 1 switch.
  - Required: next edge arst_req_o[1] = 0, en_o[1] = 1, sel_o[1] = 0, busy_o = 0, no done_o ever issued for it.
